jk_ubus_master: RTL and testbench

- Synthesizable UBUS initiator: the requesting end of the bus that the UBUS slave interface responds to.
- Accepts one command at a time from a local request port, then runs the UBUS transfer.
  - Address phase, followed by 1/2/4/8 byte-wide data phases.
  - Honours slave wait_state and error.
- Returns a single response carrying read data and status.
- Single-master system: no arbitration.

---
 rtl/jk_ubus_master.sv | 202 ++++++++++++++++++++
 tb/tb_jk_ubus_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ubus_master.sv
// UBUS initiator: takes one local command, runs the address phase and 1/2/4/8 byte
// data beats honouring slave wait_state/error, and returns one registered response.
module jk_ubus_master #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_write,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [15:0] addr,
  output logic [1:0]  size,
  output logic        read,
  output logic        write,
  output logic        bip,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  input  logic        wait_state,
  input  logic        error
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [7:0]  wait_q, wait_d;
  logic        wr_q, wr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        bip_q, bip_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        drive_s;
  logic [2:0]  last_s;

  assign last_s = 3'((4'd1 << size_q) - 4'd1);

  // Next-state and next-output logic; every bus output is computed for the coming cycle.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    wait_d        = wait_q;
    wr_d          = wr_q;
    wdata_d       = wdata_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    addr_d        = 16'h0000;
    size_d        = 2'b00;
    read_d        = 1'b0;
    write_d       = 1'b0;
    bip_d         = 1'b0;
    dout_d        = 8'h00;
    oe_d          = 1'b0;
    drive_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d       = S_ADDR;
          wr_d          = cmd_write;
          wdata_d       = cmd_wdata;
          addr_d        = cmd_addr;
          size_d        = cmd_size;
          read_d        = ~cmd_write;
          write_d       = cmd_write;
          rsp_rdata_d   = 64'h0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        beat_d  = 3'd0;
        wait_d  = 8'd0;
        drive_s = 1'b1;
      end
      S_DATA: begin
        if (error) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else if (wait_state && (wait_q == 8'(MAX_WAIT - 1))) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (wait_state) begin
          wait_d  = wait_q + 8'd1;
          drive_s = 1'b1;
        end else begin
          wait_d = 8'd0;
          if (!wr_q) begin
            rsp_rdata_d[{beat_q, 3'b000} +: 8] = data_in;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
          if (beat_q == last_s) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            beat_d  = beat_q + 3'd1;
            drive_s = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        beat_d      = 3'd0;
        wait_d      = 8'd0;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
    // Data-phase drive for the beat presented next cycle (beat_d is final here).
    if (drive_s) begin
      addr_d = addr_q;
      size_d = size_q;
      bip_d  = (beat_d != last_s);
      oe_d   = wr_q;
      dout_d = wr_q ? wdata_q[{beat_d, 3'b000} +: 8] : 8'h00;
    end else begin
      oe_d = oe_d;
    end
  end

  // State and registered-output update; reset aborts any transfer without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      beat_q        <= 3'd0;
      wait_q        <= 8'd0;
      wr_q          <= 1'b0;
      wdata_q       <= 64'h0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 64'h0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      addr_q        <= 16'h0000;
      size_q        <= 2'b00;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      bip_q         <= 1'b0;
      dout_q        <= 8'h00;
      oe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
      wr_q          <= wr_d;
      wdata_q       <= wdata_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      read_q        <= read_d;
      write_q       <= write_d;
      bip_q         <= bip_d;
      dout_q        <= dout_d;
      oe_q          <= oe_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign addr        = addr_q;
  assign size        = size_q;
  assign read        = read_q;
  assign write       = write_q;
  assign bip         = bip_q;
  assign data_out    = dout_q;
  assign data_oe     = oe_q;

endmodule

// File: tb/tb_jk_ubus_master.sv
// Bench for jk_ubus_master: a transaction-level slave/model drives each bus cycle and
// sets the expected outputs; a negedge process compares them every cycle.
module tb_jk_ubus_master;
  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, addr;
  logic [1:0]  cmd_size, size;
  logic [63:0] cmd_wdata, rsp_rdata;
  logic        rsp_valid, rsp_error, rsp_timeout;
  logic        read, write, bip, data_oe;
  logic [7:0]  data_out, data_in;
  logic        wait_state, error;

  jk_ubus_master #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .addr(addr), .size(size), .read(read), .write(write), .bip(bip),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .wait_state(wait_state), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        chk_en = 1'b0, chk_rd = 1'b0;
  logic        e_ready, e_read, e_write, e_bip, e_oe, e_rv, e_err, e_to;
  logic [15:0] e_addr;
  logic [1:0]  e_size;
  logic [7:0]  e_dout;
  logic [63:0] e_rdata;
  logic [9:0]  script[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("addr", 64'(addr), 64'(e_addr));
      chk("size", 64'(size), 64'(e_size));
      chk("read", 64'(read), 64'(e_read));
      chk("write", 64'(write), 64'(e_write));
      chk("bip", 64'(bip), 64'(e_bip));
      chk("data_oe", 64'(data_oe), 64'(e_oe));
      if (e_oe) chk("data_out", 64'(data_out), 64'(e_dout));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_error", 64'(rsp_error), 64'(e_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
      if (chk_rd) chk("rsp_rdata", rsp_rdata, e_rdata);
    end
  end

  task automatic chk_reset_outs();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_bus", {addr, size, read, write, bip, data_oe, data_out}, 64'd0);
    chk("rst_rsp", {rsp_valid, rsp_error, rsp_timeout}, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
  endtask

  task automatic set_idle_exp();
    e_ready = 1'b1; e_addr = 16'h0; e_size = 2'b0; e_read = 1'b0; e_write = 1'b0;
    e_bip = 1'b0; e_oe = 1'b0; e_dout = 8'h0; e_rv = 1'b0; chk_rd = 1'b1;
  endtask

  // One full transfer: slave behaviour per mode, expected outputs from the bus rules.
  task automatic txn(input logic [15:0] a, input logic [1:0] sz, input logic wr,
                     input logic [63:0] wd, input int mode, input int tbeat,
                     output int lat, output logic [63:0] got_rd,
                     output logic got_err, output logic got_to);
    int nb, b, w, guard;
    logic ws, er, nerr, nto, fin;
    logic [7:0] din;
    logic [63:0] mrd;
    set_idle_exp();
    cmd_valid = 1'b1; cmd_addr = a; cmd_size = sz; cmd_write = wr; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'($urandom_range(0, 1)); cmd_addr = 16'($urandom);
    cmd_size = 2'($urandom); cmd_write = 1'($urandom); cmd_wdata = {$urandom, $urandom};
    e_ready = 1'b0; e_addr = a; e_size = sz; e_read = !wr; e_write = wr;
    e_err = 1'b0; e_to = 1'b0; e_rdata = 64'h0; chk_rd = 1'b1;
    mrd = 64'h0; lat = 1;
    @(posedge clk); #1;
    nb = 1 << sz; b = 0; w = 0; fin = 1'b0; guard = 0; nerr = 1'b0; nto = 1'b0;
    chk_rd = 1'b0;
    while (!fin && guard < 4000) begin
      guard++;
      lat++;
      e_read = 1'b0; e_write = 1'b0;
      e_bip = (b < nb - 1); e_oe = wr; e_dout = wr ? wd[b*8 +: 8] : 8'h00;
      er = 1'b0; ws = 1'b0; din = 8'($urandom);
      case (mode)
        0: ws = ($urandom_range(0, 3) == 0);
        1: begin er = ($urandom_range(0, 5) == 0); ws = 1'($urandom_range(0, 1)); end
        2: ws = (b == tbeat);
        3: ws = (b == tbeat) && (w < MW - 1);
        4: if (script.size() > 0) {er, ws, din} = script.pop_front();
        default: ;
      endcase
      error = er; wait_state = ws; data_in = din;
      if (er) begin
        nerr = 1'b1; fin = 1'b1;
      end else if (ws && w == MW - 1) begin
        nto = 1'b1; fin = 1'b1;
      end else if (ws) begin
        w++;
      end else begin
        if (!wr) mrd[b*8 +: 8] = din;
        w = 0;
        if (b == nb - 1) fin = 1'b1;
        else b++;
      end
      @(posedge clk); #1;
    end
    if (!fin) begin
      failures++;
      $display("FAIL model_guard transfer did not finish within bound");
    end
    error = 1'b0; wait_state = 1'b0; cmd_valid = 1'b0;
    lat++;
    e_addr = 16'h0; e_size = 2'b0; e_bip = 1'b0; e_oe = 1'b0; e_dout = 8'h0;
    e_rv = 1'b1; e_err = nerr; e_to = nto; e_rdata = mrd; chk_rd = 1'b1;
    got_rd = rsp_rdata; got_err = rsp_error; got_to = rsp_timeout;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, mode, r, gap;
    logic [63:0] grd;
    logic gerr, gto;
    logic [1:0] sz;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 16'h0; cmd_size = 2'b0; cmd_write = 1'b0;
    cmd_wdata = 64'h0; data_in = 8'h0; wait_state = 1'b0; error = 1'b0;
    #3;
    chk_reset_outs();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    e_err = 1'b0; e_to = 1'b0; e_rdata = 64'h0;
    set_idle_exp();
    chk_en = 1'b1;

    // Write 1 byte, no waits
    txn(16'h1234, 2'b00, 1'b1, 64'h0000_0000_0000_00A5, 4, 0, lat, grd, gerr, gto);
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_error", 64'(gerr), 64'd0);

    // Read 4 bytes
    script.push_back({2'b00, 8'h11}); script.push_back({2'b00, 8'h22});
    script.push_back({2'b00, 8'h33}); script.push_back({2'b00, 8'h44});
    txn(16'h0100, 2'b10, 1'b0, 64'h0, 4, 0, lat, grd, gerr, gto);
    chk("t2_rdata", grd, 64'h0000_0000_4433_2211);
    chk("t2_latency", 64'(lat), 64'd6);

    // Write 2 bytes, three stalls on beat 1
    script.delete();
    script.push_back({2'b00, 8'h00}); script.push_back({2'b01, 8'h00});
    script.push_back({2'b01, 8'h00}); script.push_back({2'b01, 8'h00});
    script.push_back({2'b00, 8'h00});
    txn(16'h0200, 2'b01, 1'b1, 64'h0000_0000_0000_BEEF, 4, 0, lat, grd, gerr, gto);
    chk("t3_latency", 64'(lat), 64'd7);
    chk("t3_error", 64'(gerr), 64'd0);

    // Read 8 bytes, error on beat 2
    script.delete();
    script.push_back({2'b00, 8'h11}); script.push_back({2'b00, 8'h22});
    script.push_back({2'b10, 8'h33});
    txn(16'h0300, 2'b11, 1'b0, 64'h0, 4, 0, lat, grd, gerr, gto);
    chk("t4_error", 64'(gerr), 64'd1);
    chk("t4_rdata", grd, 64'h0000_0000_0000_2211);
    chk("t4_latency", 64'(lat), 64'd5);

    // Endless stall on beat 0
    txn(16'h0400, 2'b00, 1'b0, 64'h0, 2, 0, lat, grd, gerr, gto);
    chk("t5_timeout", 64'(gto), 64'd1);
    chk("t5_latency", 64'(lat), 64'd18);
    chk("t5_ready_after", 64'(cmd_ready), 64'd1);

    // Exactly MAX_WAIT-1 stalls must not time out
    txn(16'h0500, 2'b01, 1'b1, 64'h0000_0000_0000_1234, 3, 1, lat, grd, gerr, gto);
    chk("boundary_no_timeout", 64'(gto), 64'd0);
    chk("boundary_latency", 64'(lat), 64'd4 + 64'(MW - 1));

    // Reset during beat 3 of an 8-byte read
    chk_en = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 16'h0600; cmd_size = 2'b11; cmd_write = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin data_in = 8'($urandom); @(posedge clk); #1; end
    chk("t6_bip_before_reset", 64'(bip), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_outs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    e_err = 1'b0; e_to = 1'b0; e_rdata = 64'h0;
    set_idle_exp();
    chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    txn(16'h0700, 2'b01, 1'b0, 64'h0, 0, 0, lat, grd, gerr, gto);
    chk("t6_after_reset_ok", {62'd0, gerr, gto}, 64'd0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin set_idle_exp(); @(posedge clk); #1; end
      r = $urandom_range(0, 9);
      mode = (r < 5) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
      sz = 2'($urandom);
      txn(16'($urandom), sz, 1'($urandom), {$urandom, $urandom}, mode,
          $urandom_range(0, (1 << sz) - 1), lat, grd, gerr, gto);
    end
    set_idle_exp();
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
